// File: rtl/mvb_pkg.sv
// Shared definitions for the MVB delimiter sequencer: fmt codes, default
// delimiter patterns/lengths, FSM state type and a max-length helper.
package mvb_pkg;

    localparam logic [1:0] FMT_ILLEGAL = 2'b00;
    localparam logic [1:0] FMT_MASTER  = 2'b01;
    localparam logic [1:0] FMT_SLAVE   = 2'b10;
    localparam logic [1:0] FMT_END     = 2'b11;

    localparam int unsigned M_LEN_DEF = 18;
    localparam int unsigned S_LEN_DEF = 18;
    localparam int unsigned E_LEN_DEF = 4;

    localparam logic [17:0] M_PAT_DEF = 18'b111001001001000000;
    localparam logic [17:0] S_PAT_DEF = 18'b111111110110110110;
    localparam logic [3:0]  E_PAT_DEF = 4'b0110;

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_SEND = 1'b1
    } state_e;

    function automatic int unsigned max_len(input int unsigned a,
                                            input int unsigned b,
                                            input int unsigned c);
        int unsigned m;
        m = (a > b) ? a : b;
        return (m > c) ? m : c;
    endfunction

endpackage

// File: rtl/mvb_sym_ticker.sv
// Symbol hold counter: counts 0..OVS-1 while enabled and flags the last
// clock of each symbol with sym_last.
module mvb_sym_ticker #(
    parameter int unsigned OVS = 1
) (
    input  logic clk_3M,
    input  logic reset,
    input  logic clr,
    input  logic en,
    output logic sym_last
);

    localparam int unsigned        HOLD_W   = $clog2(OVS) + 1;
    localparam logic [HOLD_W-1:0]  HOLD_MAX = HOLD_W'(OVS - 1);

    logic [HOLD_W-1:0] hold_q, hold_d;

    assign sym_last = en && (hold_q == HOLD_MAX);

    always_comb begin
        hold_d = hold_q;
        if (clr) begin
            hold_d = '0;
        end else if (en) begin
            hold_d = sym_last ? '0 : hold_q + 1'b1;
        end
    end

    always_ff @(posedge clk_3M) begin
        if (reset) begin
            hold_q <= '0;
        end else begin
            hold_q <= hold_d;
        end
    end

endmodule

// File: rtl/mvb_delim_seq.sv
// MVB frame-delimiter sequencer: latches a delimiter on start/ready and
// shifts it MSB-first onto line_out, each symbol held for OVS clocks.
module mvb_delim_seq
    import mvb_pkg::*;
#(
    parameter int unsigned       OVS      = 1,
    parameter logic              IDLE_LVL = 1'b0,
    parameter int unsigned       M_LEN    = M_LEN_DEF,
    parameter int unsigned       S_LEN    = S_LEN_DEF,
    parameter int unsigned       E_LEN    = E_LEN_DEF,
    parameter logic [M_LEN-1:0]  M_PAT    = M_PAT_DEF,
    parameter logic [S_LEN-1:0]  S_PAT    = S_PAT_DEF,
    parameter logic [E_LEN-1:0]  E_PAT    = E_PAT_DEF
) (
    input  logic       clk_3M,
    input  logic       reset,
    input  logic       start,
    input  logic [1:0] fmt,
    input  logic       abort,
    output logic       ready,
    output logic       tx_en,
    output logic       line_out,
    output logic       done,
    output logic       fmt_err,
    output logic       aborted
);

    localparam int unsigned MAX_W = max_len(M_LEN, S_LEN, E_LEN);
    localparam int unsigned SYM_W = $clog2(MAX_W) + 1;

    // Patterns left-aligned so the first symbol is always at bit MAX_W-1.
    localparam logic [MAX_W-1:0] M_AL = MAX_W'(M_PAT) << (MAX_W - M_LEN);
    localparam logic [MAX_W-1:0] S_AL = MAX_W'(S_PAT) << (MAX_W - S_LEN);
    localparam logic [MAX_W-1:0] E_AL = MAX_W'(E_PAT) << (MAX_W - E_LEN);

    state_e            state_q, state_d;
    logic [MAX_W-1:0]  sr_q, sr_d;
    logic [SYM_W-1:0]  sym_q, sym_d;
    logic [SYM_W-1:0]  last_q, last_d;
    logic              ready_q, ready_d;
    logic              tx_en_q, tx_en_d;
    logic              line_q, line_d;
    logic              done_q, done_d;
    logic              fmt_err_q, fmt_err_d;
    logic              aborted_q, aborted_d;

    logic [MAX_W-1:0]  pat_sel;
    logic [SYM_W-1:0]  last_sel;
    logic              sym_last;
    logic              tick_en;
    logic              tick_clr;

    assign tick_en  = (state_q == ST_SEND);
    assign tick_clr = (state_q != ST_SEND) || abort;

    mvb_sym_ticker #(
        .OVS (OVS)
    ) u_ticker (
        .clk_3M   (clk_3M),
        .reset    (reset),
        .clr      (tick_clr),
        .en       (tick_en),
        .sym_last (sym_last)
    );

    always_comb begin
        pat_sel  = M_AL;
        last_sel = SYM_W'(M_LEN - 1);
        unique case (fmt)
            FMT_SLAVE: begin
                pat_sel  = S_AL;
                last_sel = SYM_W'(S_LEN - 1);
            end
            FMT_END: begin
                pat_sel  = E_AL;
                last_sel = SYM_W'(E_LEN - 1);
            end
            default: ;
        endcase
    end

    always_comb begin
        state_d   = state_q;
        sr_d      = sr_q;
        sym_d     = sym_q;
        last_d    = last_q;
        ready_d   = ready_q;
        tx_en_d   = tx_en_q;
        line_d    = line_q;
        done_d    = 1'b0;
        fmt_err_d = 1'b0;
        aborted_d = 1'b0;
        case (state_q)
            ST_IDLE: begin
                ready_d = 1'b1;
                tx_en_d = 1'b0;
                line_d  = IDLE_LVL;
                if (start && ready_q) begin
                    if (fmt == FMT_ILLEGAL) begin
                        fmt_err_d = 1'b1;
                    end else begin
                        state_d = ST_SEND;
                        sr_d    = pat_sel;
                        sym_d   = '0;
                        last_d  = last_sel;
                        ready_d = 1'b0;
                        tx_en_d = 1'b1;
                        line_d  = pat_sel[MAX_W-1];
                    end
                end
            end
            ST_SEND: begin
                // abort has priority over the final-symbol completion
                if (abort) begin
                    state_d   = ST_IDLE;
                    ready_d   = 1'b1;
                    tx_en_d   = 1'b0;
                    line_d    = IDLE_LVL;
                    aborted_d = 1'b1;
                end else if (sym_last) begin
                    if (sym_q == last_q) begin
                        state_d = ST_IDLE;
                        ready_d = 1'b1;
                        tx_en_d = 1'b0;
                        line_d  = IDLE_LVL;
                        done_d  = 1'b1;
                    end else begin
                        sr_d   = sr_q << 1;
                        sym_d  = sym_q + 1'b1;
                        line_d = sr_d[MAX_W-1];
                    end
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_3M) begin
        if (reset) begin
            state_q   <= ST_IDLE;
            sr_q      <= '0;
            sym_q     <= '0;
            last_q    <= '0;
            ready_q   <= 1'b1;
            tx_en_q   <= 1'b0;
            line_q    <= IDLE_LVL;
            done_q    <= 1'b0;
            fmt_err_q <= 1'b0;
            aborted_q <= 1'b0;
        end else begin
            state_q   <= state_d;
            sr_q      <= sr_d;
            sym_q     <= sym_d;
            last_q    <= last_d;
            ready_q   <= ready_d;
            tx_en_q   <= tx_en_d;
            line_q    <= line_d;
            done_q    <= done_d;
            fmt_err_q <= fmt_err_d;
            aborted_q <= aborted_d;
        end
    end

    assign ready    = ready_q;
    assign tx_en    = tx_en_q;
    assign line_out = line_q;
    assign done     = done_q;
    assign fmt_err  = fmt_err_q;
    assign aborted  = aborted_q;

endmodule

// File: tb/tb_mvb_delim_seq.sv
// Bench for mvb_delim_seq: two instances (OVS=1, OVS=2) share stimulus and are
// compared every cycle against a time-indexed model of the delimiter timing.
module tb_mvb_delim_seq;

    logic       clk_3M;
    logic       reset;
    logic       start;
    logic [1:0] fmt;
    logic       abort;

    logic ready   [2];
    logic tx_en   [2];
    logic line_out[2];
    logic done    [2];
    logic fmt_err [2];
    logic aborted [2];

    int unsigned n_cmp;
    int unsigned n_err;
    int unsigned cyc;

    // reference model state per instance
    int unsigned ovs_of [2];
    bit          m_busy [2];
    int unsigned m_t    [2];
    int unsigned m_len  [2];
    logic [17:0] m_pat  [2];
    logic e_ready[2], e_tx[2], e_line[2], e_done[2], e_ferr[2], e_abt[2];

    logic [17:0] pat_m, pat_s, pat_e;

    mvb_delim_seq #(.OVS(1)) u_dut1 (
        .clk_3M(clk_3M), .reset(reset), .start(start), .fmt(fmt), .abort(abort),
        .ready(ready[0]), .tx_en(tx_en[0]), .line_out(line_out[0]),
        .done(done[0]), .fmt_err(fmt_err[0]), .aborted(aborted[0])
    );

    mvb_delim_seq #(.OVS(2)) u_dut2 (
        .clk_3M(clk_3M), .reset(reset), .start(start), .fmt(fmt), .abort(abort),
        .ready(ready[1]), .tx_en(tx_en[1]), .line_out(line_out[1]),
        .done(done[1]), .fmt_err(fmt_err[1]), .aborted(aborted[1])
    );

    initial clk_3M = 1'b0;
    always #5 clk_3M = ~clk_3M;

    task automatic chk(input string tag, input logic obs, input logic exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s cyc=%0d observed=%b expected=%b", tag, cyc, obs, exp);
        end
    endtask

    task automatic go_idle(input int i);
        m_busy[i]  = 1'b0;
        e_ready[i] = 1'b1;
        e_tx[i]    = 1'b0;
        e_line[i]  = 1'b0;
    endtask

    // Outputs for the next cycle, given this cycle's inputs.
    task automatic model(input int i, input bit st, input logic [1:0] f,
                         input bit ab, input bit rs);
        e_done[i] = 1'b0;
        e_ferr[i] = 1'b0;
        e_abt[i]  = 1'b0;
        if (rs) begin
            go_idle(i);
        end else if (m_busy[i]) begin
            if (ab) begin
                go_idle(i);
                e_abt[i] = 1'b1;
            end else begin
                m_t[i]++;
                if (m_t[i] > m_len[i] * ovs_of[i]) begin
                    go_idle(i);
                    e_done[i] = 1'b1;
                end else begin
                    e_line[i] = m_pat[i][m_len[i] - 1 - (m_t[i] - 1) / ovs_of[i]];
                end
            end
        end else if (st) begin
            if (f == 2'b00) begin
                e_ferr[i] = 1'b1;
            end else begin
                case (f)
                    2'b01:   begin m_pat[i] = pat_m; m_len[i] = 18; end
                    2'b10:   begin m_pat[i] = pat_s; m_len[i] = 18; end
                    default: begin m_pat[i] = pat_e; m_len[i] = 4;  end
                endcase
                m_busy[i]  = 1'b1;
                m_t[i]     = 1;
                e_ready[i] = 1'b0;
                e_tx[i]    = 1'b1;
                e_line[i]  = m_pat[i][m_len[i] - 1];
            end
        end
    endtask

    task automatic step(input bit st, input logic [1:0] f, input bit ab, input bit rs);
        start = st;
        fmt   = f;
        abort = ab;
        reset = rs;
        for (int i = 0; i < 2; i++) model(i, st, f, ab, rs);
        @(posedge clk_3M);
        #1;
        cyc++;
        for (int i = 0; i < 2; i++) begin
            chk($sformatf("ovs%0d.ready", ovs_of[i]),    ready[i],    e_ready[i]);
            chk($sformatf("ovs%0d.tx_en", ovs_of[i]),    tx_en[i],    e_tx[i]);
            chk($sformatf("ovs%0d.line_out", ovs_of[i]), line_out[i], e_line[i]);
            chk($sformatf("ovs%0d.done", ovs_of[i]),     done[i],     e_done[i]);
            chk($sformatf("ovs%0d.fmt_err", ovs_of[i]),  fmt_err[i],  e_ferr[i]);
            chk($sformatf("ovs%0d.aborted", ovs_of[i]),  aborted[i],  e_abt[i]);
        end
    endtask

    task automatic idle(input int unsigned n);
        for (int unsigned k = 0; k < n; k++) step(1'b0, 2'b00, 1'b0, 1'b0);
    endtask

    initial begin
        n_cmp = 0;
        n_err = 0;
        cyc   = 0;
        ovs_of[0] = 1;
        ovs_of[1] = 2;
        pat_m = 18'b111001001001000000;
        pat_s = 18'b111111110110110110;
        pat_e = 18'b000000000000000110;
        for (int i = 0; i < 2; i++) begin
            m_busy[i] = 1'b0; m_t[i] = 0; m_len[i] = 0; m_pat[i] = '0;
        end
        start = 1'b0; fmt = 2'b00; abort = 1'b0; reset = 1'b1;

        // reset values
        step(1'b0, 2'b00, 1'b0, 1'b1);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        idle(2);

        // master, slave
        step(1'b1, 2'b01, 1'b0, 1'b0);
        idle(40);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        idle(40);

        // end delimiter, then start in the done cycle (cycle 5) with master
        step(1'b1, 2'b11, 1'b0, 1'b0);
        idle(4);
        step(1'b1, 2'b01, 1'b0, 1'b0);
        idle(40);

        // illegal fmt
        step(1'b1, 2'b00, 1'b0, 1'b0);
        idle(3);

        // abort at cycle 7
        step(1'b1, 2'b01, 1'b0, 1'b0);
        idle(6);
        step(1'b0, 2'b00, 1'b1, 1'b0);
        idle(40);

        // abort on last master symbol (cycle 18 for OVS=1)
        step(1'b1, 2'b01, 1'b0, 1'b0);
        idle(17);
        step(1'b0, 2'b00, 1'b1, 1'b0);
        idle(40);

        // abort while idle is ignored
        step(1'b0, 2'b00, 1'b1, 1'b0);
        idle(2);

        // reset at cycle 5 of slave, then full slave
        step(1'b1, 2'b10, 1'b0, 1'b0);
        idle(4);
        step(1'b0, 2'b00, 1'b0, 1'b1);
        step(1'b1, 2'b10, 1'b0, 1'b0);
        idle(40);

        // randomized traffic
        for (int unsigned k = 0; k < 1500; k++) begin
            step($urandom_range(0, 3) == 0,
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 29) == 0,
                 $urandom_range(0, 199) == 0);
        end
        idle(40);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
